// File: rtl/io_dev_pkg.sv
// Shared types and defaults for the io_device_mc block:
// FSM state encoding, default parameter values and an index-width helper.
package io_dev_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_TMO    = 15;

    typedef enum logic [2:0] {
        IDLE,
        HRD_WAIT,
        HRD_RESP,
        REQ,
        ACK
    } state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_device_mc_rr_arbiter.sv
// Round-robin arbiter: picks the first pending channel at or after ptr.
// Ports: pending (request vector), ptr (search start), grant (one-hot or zero).
module rr_arbiter
    import io_dev_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PTR_W  = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!found && pending[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_device_mc.sv
// Host-accessible memory plus a round-robin DMA request engine.
// Ports: clk/rst; per-channel req_trig/req_dir/req_wc/req_data; DREQ/DACK
// handshake; wrReq strobe with IO_out/WORD_COUNT/DB_out/address_sent_to_io;
// host bus ENABLE/IO_in/ADDRESS/DB_in; sticky err flags; busy.
module io_device_mc
    import io_dev_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int TMO    = DEF_TMO
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_trig,
    input  logic [NUM_CH-1:0]        req_dir,
    input  logic [NUM_CH*8-1:0]      req_wc,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        DREQ,
    input  logic [NUM_CH-1:0]        DACK,
    output logic                     wrReq,
    output logic                     IO_out,
    output logic [7:0]               WORD_COUNT,
    output logic [DATA_W-1:0]        DB_out,
    input  logic                     ENABLE,
    input  logic                     IO_in,
    input  logic [ADDR_W-1:0]        ADDRESS,
    input  logic [DATA_W-1:0]        DB_in,
    output logic [ADDR_W-1:0]        address_sent_to_io,
    output logic [NUM_CH-1:0]        err,
    output logic                     busy
);

    localparam int PTR_W = idx_w(NUM_CH);
    localparam int CNT_W = $clog2(TMO + 1);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] arb_grant;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] set;
    logic [NUM_CH-1:0] dir_q;
    logic [7:0]        wc_q   [NUM_CH];
    logic [DATA_W-1:0] data_q [NUM_CH];

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  arb_idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] rd_addr;

    logic              host_rd;
    logic              acked;
    logic              timeout;
    logic              done;
    logic              g_dir;
    logic [7:0]        g_wc;
    logic [DATA_W-1:0] g_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_arb (
        .pending (pending),
        .ptr     (ptr),
        .grant   (arb_grant)
    );

    assign host_rd = ENABLE && IO_in;
    assign acked   = (state == REQ) && (|(DACK & grant));
    assign timeout = (state == REQ) && !acked
                   && (wait_cnt == CNT_W'(TMO - 1));
    assign done    = (state == ACK) || timeout;
    assign clr     = done ? grant : '0;
    // A channel finishing this cycle may take a fresh trigger at once.
    assign set     = req_trig & (~pending | clr);

    assign wrReq = (state == HRD_RESP) || (state == ACK);
    assign DREQ  = (state == REQ) ? grant : '0;
    assign busy  = (state != IDLE);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (host_rd) begin
                    next_state = HRD_WAIT;
                end else if (|pending) begin
                    next_state = REQ;
                end
            end
            HRD_WAIT: next_state = HRD_RESP;
            HRD_RESP: next_state = IDLE;
            REQ: begin
                if (acked) begin
                    next_state = ACK;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            ACK:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        g_dir   = 1'b0;
        g_wc    = '0;
        g_data  = '0;
        arb_idx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                g_dir  = dir_q[c];
                g_wc   = wc_q[c];
                g_data = data_q[c];
            end
            if (arb_grant[c]) begin
                arb_idx = PTR_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            grant    <= '0;
            ptr      <= '0;
            wait_cnt <= '0;
            rd_addr  <= '0;
            err      <= '0;
        end else begin
            state   <= next_state;
            pending <= set | (pending & ~clr);
            if (timeout) begin
                err <= err | grant;
            end
            if (state == IDLE && host_rd) begin
                rd_addr <= ADDRESS;
            end
            if (state == IDLE && next_state == REQ) begin
                grant <= arb_grant;
                ptr   <= (arb_idx == PTR_W'(NUM_CH - 1))
                       ? '0 : arb_idx + 1'b1;
            end
            if (state == REQ && next_state == REQ) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Descriptors are only meaningful while pending, so no reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (set[c]) begin
                dir_q[c]  <= req_dir[c];
                wc_q[c]   <= req_wc[c*8 +: 8];
                data_q[c] <= req_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Strobe payload is loaded on the edge entering HRD_RESP or ACK,
    // then held until the next strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            IO_out             <= 1'b0;
            WORD_COUNT         <= '0;
            DB_out             <= '0;
            address_sent_to_io <= '0;
        end else if (state == HRD_WAIT) begin
            DB_out             <= mem[rd_addr];
            address_sent_to_io <= rd_addr;
        end else if (acked) begin
            IO_out     <= g_dir;
            WORD_COUNT <= g_wc;
            DB_out     <= g_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (ENABLE && !IO_in) begin
            mem[ADDRESS] <= DB_in;
        end
    end

endmodule

// File: tb/tb_io_device_mc.sv
// Directed bench for io_device_mc: vector table for host and
// single-channel traffic, hand sequences for arbitration and timeouts.
module tb_io_device_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_trig;
    logic [1:0]  req_dir;
    logic [15:0] req_wc;
    logic [15:0] req_data;
    logic [1:0]  DREQ;
    logic [1:0]  DACK;
    logic        wrReq;
    logic        IO_out;
    logic [7:0]  WORD_COUNT;
    logic [7:0]  DB_out;
    logic        ENABLE;
    logic        IO_in;
    logic [4:0]  ADDRESS;
    logic [7:0]  DB_in;
    logic [4:0]  address_sent_to_io;
    logic [1:0]  err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_device_mc dut (
        .clk                (clk),
        .rst                (rst),
        .req_trig           (req_trig),
        .req_dir            (req_dir),
        .req_wc             (req_wc),
        .req_data           (req_data),
        .DREQ               (DREQ),
        .DACK               (DACK),
        .wrReq              (wrReq),
        .IO_out             (IO_out),
        .WORD_COUNT         (WORD_COUNT),
        .DB_out             (DB_out),
        .ENABLE             (ENABLE),
        .IO_in              (IO_in),
        .ADDRESS            (ADDRESS),
        .DB_in              (DB_in),
        .address_sent_to_io (address_sent_to_io),
        .err                (err),
        .busy               (busy)
    );

    typedef struct {
        logic        en;
        logic        io;
        logic [4:0]  addr;
        logic [7:0]  db;
        logic [1:0]  trig;
        logic [1:0]  dir;
        logic [15:0] wc;
        logic [15:0] data;
        logic [1:0]  dack;
        logic        wr;
        logic [1:0]  dreq;
        logic        bsy;
        logic        cd;
        logic        io_o;
        logic [7:0]  wc_o;
        logic [7:0]  db_o;
        logic [4:0]  a_o;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_trig = '0;
        req_dir  = '0;
        req_wc   = '0;
        req_data = '0;
        DACK     = '0;
        ENABLE   = 1'b0;
        IO_in    = 1'b0;
        ADDRESS  = '0;
        DB_in    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_ch(input int c, input logic d,
                          input logic [7:0] wc, input logic [7:0] data);
        req_dir[c]        = d;
        req_wc[c*8 +: 8]  = wc;
        req_data[c*8 +: 8] = data;
    endtask

    task automatic wait_dreq(input string name, input logic [1:0] exp);
        int n = 0;
        while (DREQ == 2'b00 && n < 10) begin
            step();
            n++;
        end
        chk(name, DREQ, exp);
    endtask

    task automatic ack_and_check(input string name, input logic [1:0] ch,
                                 input logic io, input logic [7:0] wc,
                                 input logic [7:0] db);
        DACK = ch;
        step();
        DACK = '0;
        chk({name, " wrReq"}, wrReq, 1'b1);
        chk({name, " dreq"}, DREQ, 2'b00);
        chk({name, " io"}, IO_out, io);
        chk({name, " wc"}, WORD_COUNT, wc);
        chk({name, " db"}, DB_out, db);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   hi;
        logic seen;

        // en io addr db | trig dir wc data dack | wr dreq bsy cd io wc db a
        vecs[0]  = '{1, 0, 3, 8'hA5, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 3, 0, 0, 0, 0, 0, 0,
                     0, 0, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 3, 0, 0, 0, 0, 0, 0,
                     1, 0, 1, 1, 0, 0, 8'hA5, 3};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 1, 0, 0, 8'hA5, 3};
        vecs[4]  = '{1, 1, 7, 0, 0, 0, 0, 0, 0,
                     0, 0, 1, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 1, 7, 0, 0, 0, 0, 0, 0,
                     1, 0, 1, 1, 0, 0, 8'h07, 7};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 1, 0, 0, 8'h07, 7};
        vecs[7]  = '{0, 0, 0, 0, 2'b01, 0, 16'h0007, 16'h0041, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 2'b01, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 2'b01, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 2'b01, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b01,
                     1, 0, 1, 1, 0, 8'd7, 8'h41, 7};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 1, 0, 8'd7, 8'h41, 7};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};

        do_reset();
        chk("rst DREQ", DREQ, 2'b00);
        chk("rst wrReq", wrReq, 1'b0);
        chk("rst IO_out", IO_out, 1'b0);
        chk("rst WORD_COUNT", WORD_COUNT, 8'h00);
        chk("rst DB_out", DB_out, 8'h00);
        chk("rst addr", address_sent_to_io, 5'h00);
        chk("rst err", err, 2'b00);
        chk("rst busy", busy, 1'b0);

        for (int i = 0; i < NV; i++) begin
            ENABLE   = vecs[i].en;
            IO_in    = vecs[i].io;
            ADDRESS  = vecs[i].addr;
            DB_in    = vecs[i].db;
            req_trig = vecs[i].trig;
            req_dir  = vecs[i].dir;
            req_wc   = vecs[i].wc;
            req_data = vecs[i].data;
            DACK     = vecs[i].dack;
            step();
            chk($sformatf("v%0d wrReq", i), wrReq, vecs[i].wr);
            chk($sformatf("v%0d DREQ", i), DREQ, vecs[i].dreq);
            chk($sformatf("v%0d busy", i), busy, vecs[i].bsy);
            if (vecs[i].cd) begin
                chk($sformatf("v%0d IO_out", i), IO_out, vecs[i].io_o);
                chk($sformatf("v%0d WC", i), WORD_COUNT, vecs[i].wc_o);
                chk($sformatf("v%0d DB_out", i), DB_out, vecs[i].db_o);
                chk($sformatf("v%0d addr", i), address_sent_to_io,
                    vecs[i].a_o);
            end
        end
        clear_inputs();

        // Round-robin with ignored retrigger and same-cycle re-arm.
        do_reset();
        set_ch(0, 1'b1, 8'd2, 8'h11);
        set_ch(1, 1'b0, 8'd3, 8'h22);
        req_trig = 2'b11;
        step();
        req_trig = '0;
        wait_dreq("rr1 grant", 2'b01);
        set_ch(1, 1'b1, 8'd9, 8'h99);
        req_trig = 2'b10;
        ack_and_check("rr1", 2'b01, 1'b1, 8'd2, 8'h11);
        req_trig = '0;
        wait_dreq("rr2 grant", 2'b10);
        ack_and_check("rr2", 2'b10, 1'b0, 8'd3, 8'h22);
        set_ch(0, 1'b0, 8'd4, 8'h33);
        set_ch(1, 1'b1, 8'd5, 8'h44);
        req_trig = 2'b11;
        step();
        req_trig = '0;
        wait_dreq("rr3 grant", 2'b01);
        ack_and_check("rr3", 2'b01, 1'b0, 8'd4, 8'h33);
        wait_dreq("rr4 grant", 2'b10);
        ack_and_check("rr4", 2'b10, 1'b1, 8'd5, 8'h44);
        step();
        chk("rr idle", busy, 1'b0);

        // Timeout on channel 1, then a fresh request on it.
        do_reset();
        set_ch(1, 1'b0, 8'd1, 8'h5A);
        req_trig = 2'b10;
        step();
        req_trig = '0;
        wait_dreq("tmo grant", 2'b10);
        hi   = 1;
        seen = 1'b0;
        while (DREQ != 2'b00 && hi < 40) begin
            step();
            if (wrReq) seen = 1'b1;
            if (DREQ != 2'b00) hi++;
        end
        chk("tmo dreq cycles", hi, 15);
        chk("tmo err", err, 2'b10);
        chk("tmo no wrReq", seen, 1'b0);
        chk("tmo busy", busy, 1'b0);
        req_trig = 2'b10;
        step();
        req_trig = '0;
        wait_dreq("tmo retrig grant", 2'b10);
        ack_and_check("tmo retrig", 2'b10, 1'b0, 8'd1, 8'h5A);
        chk("tmo err sticky", err, 2'b10);

        // Host read beats a channel already pending in IDLE.
        do_reset();
        set_ch(0, 1'b0, 8'd1, 8'h77);
        req_trig = 2'b01;
        step();
        req_trig = '0;
        ENABLE   = 1'b1;
        IO_in    = 1'b1;
        ADDRESS  = 5'd5;
        step();
        chk("prio busy", busy, 1'b1);
        chk("prio dreq wait", DREQ, 2'b00);
        step();
        chk("prio wrReq", wrReq, 1'b1);
        chk("prio dreq resp", DREQ, 2'b00);
        chk("prio db", DB_out, 8'h05);
        chk("prio addr", address_sent_to_io, 5'd5);
        ENABLE = 1'b0;
        IO_in  = 1'b0;
        wait_dreq("prio grant", 2'b01);
        ack_and_check("prio ch0", 2'b01, 1'b0, 8'd1, 8'h77);

        // Reset mid-handshake; memory reloads its index pattern.
        do_reset();
        set_ch(0, 1'b1, 8'd6, 8'hC3);
        req_trig = 2'b01;
        step();
        req_trig = '0;
        wait_dreq("rreq grant", 2'b01);
        ENABLE  = 1'b1;
        IO_in   = 1'b0;
        ADDRESS = 5'd5;
        DB_in   = 8'hEE;
        step();
        ENABLE = 1'b0;
        chk("rreq still req", DREQ, 2'b01);
        rst  = 1'b1;
        DACK = 2'b01;
        step();
        chk("rreq dreq", DREQ, 2'b00);
        chk("rreq busy", busy, 1'b0);
        chk("rreq wrReq", wrReq, 1'b0);
        rst  = 1'b0;
        DACK = '0;
        seen = 1'b0;
        repeat (3) begin
            step();
            if (wrReq) seen = 1'b1;
        end
        chk("rreq no wrReq", seen, 1'b0);
        ENABLE  = 1'b1;
        IO_in   = 1'b1;
        ADDRESS = 5'd5;
        step();
        step();
        chk("rreq rd wrReq", wrReq, 1'b1);
        chk("rreq rd db", DB_out, 8'h05);
        ENABLE = 1'b0;
        IO_in  = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
